// File: rtl/fpga_rst_strap_seq_if.sv
// Pad-side and status signals of the reset sequencer / strap sampler.
// The master modport drives the pads; the slave modport is the sequencer.
interface fpga_rst_strap_seq_if #(
  parameter int NumRstSrc  = 2,
  parameter int NumDomains = 3,
  parameter int NumStraps  = 2
);
  logic [NumRstSrc-1:0]  rst_req_i;
  logic                  pll_locked_i;
  logic [NumStraps-1:0]  strap_i;
  logic                  cause_clr_i;
  logic [NumDomains-1:0] rst_domain_no;
  logic [NumStraps-1:0]  strap_o;
  logic                  strap_valid_o;
  logic [NumRstSrc-1:0]  rst_cause_o;
  logic                  lock_lost_o;

  modport master (
    output rst_req_i, pll_locked_i, strap_i, cause_clr_i,
    input  rst_domain_no, strap_o, strap_valid_o, rst_cause_o, lock_lost_o
  );

  modport slave (
    input  rst_req_i, pll_locked_i, strap_i, cause_clr_i,
    output rst_domain_no, strap_o, strap_valid_o, rst_cause_o, lock_lost_o
  );
endinterface

// File: rtl/fpga_rst_strap_seq.sv
// Reset sequencer: synchronises/debounces reset requests and PLL lock, latches
// boot straps once per sequence, releases domain resets staggered, records cause.
module fpga_rst_strap_seq #(
  parameter int NumRstSrc      = 2,
  parameter int NumDomains     = 3,
  parameter int NumStraps      = 2,
  parameter int DebounceCycles = 16,
  parameter int StaggerCycles  = 8
) (
  input logic clk_i,
  input logic rst_i,
  fpga_rst_strap_seq_if.slave bus
);

  localparam int CntMax = (DebounceCycles > StaggerCycles) ? DebounceCycles : StaggerCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] StgLast = CntW'(StaggerCycles - 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_QUIET,
    ST_STRAP,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [NumRstSrc-1:0]  req_meta_reg, req_sync_reg;
  logic                  lock_meta_reg, lock_sync_reg;
  logic [NumStraps-1:0]  strap_meta_reg, strap_sync_reg;

  state_t                state_reg, state_next;
  logic [CntW-1:0]       cnt_reg, cnt_next;
  logic [NumDomains-1:0] dom_reg, dom_next, dom_shift;
  logic [NumStraps-1:0]  strap_reg, strap_next;
  logic                  valid_reg, valid_next;
  logic [NumRstSrc-1:0]  cause_reg, cause_next;
  logic                  lock_lost_reg, lock_lost_next;
  logic                  set_cause;
  logic                  clean;

  // Request syncs reset to "requesting" and lock to "unlocked" so the
  // sequencer never sees a spurious clean window straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_meta_reg   <= '1;
      req_sync_reg   <= '1;
      lock_meta_reg  <= 1'b0;
      lock_sync_reg  <= 1'b0;
      strap_meta_reg <= '0;
      strap_sync_reg <= '0;
    end else begin
      req_meta_reg   <= bus.rst_req_i;
      req_sync_reg   <= req_meta_reg;
      lock_meta_reg  <= bus.pll_locked_i;
      lock_sync_reg  <= lock_meta_reg;
      strap_meta_reg <= bus.strap_i;
      strap_sync_reg <= strap_meta_reg;
    end
  end

  assign clean = ~|req_sync_reg & lock_sync_reg;

  // Thermometer step: releasing the next domain shifts in one more '1'.
  generate
    for (genvar gi = 0; gi < NumDomains; gi++) begin : g_shift
      if (gi == 0) begin : g_first
        assign dom_shift[gi] = 1'b1;
      end else begin : g_rest
        assign dom_shift[gi] = dom_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_ASSERT;
      cnt_reg       <= '0;
      dom_reg       <= '0;
      strap_reg     <= '0;
      valid_reg     <= 1'b0;
      cause_reg     <= '0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      dom_reg       <= dom_next;
      strap_reg     <= strap_next;
      valid_reg     <= valid_next;
      cause_reg     <= cause_next;
      lock_lost_reg <= lock_lost_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dom_next   = dom_reg;
    strap_next = strap_reg;
    valid_next = valid_reg;
    set_cause  = 1'b0;

    if (state_reg != ST_ASSERT && !clean) begin
      state_next = ST_ASSERT;
      cnt_next   = '0;
      dom_next   = '0;
      valid_next = 1'b0;
      // Noise while still debouncing is not a reset cause; only a drop out of
      // an established sequence is.
      set_cause  = (state_reg != ST_QUIET);
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          cnt_next   = '0;
          dom_next   = '0;
          valid_next = 1'b0;
          if (clean) state_next = ST_QUIET;
        end
        ST_QUIET: begin
          if (cnt_reg == DebLast) begin
            state_next = ST_STRAP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CntW'(1);
          end
        end
        ST_STRAP: begin
          strap_next = strap_sync_reg;
          valid_next = 1'b1;
          dom_next   = dom_shift;
          cnt_next   = '0;
          state_next = (NumDomains == 1) ? ST_RUN : ST_RELEASE;
        end
        ST_RELEASE: begin
          if (cnt_reg == StgLast) begin
            dom_next = dom_shift;
            cnt_next = '0;
            if (dom_shift[NumDomains-1]) state_next = ST_RUN;
          end else begin
            cnt_next = cnt_reg + CntW'(1);
          end
        end
        default: ;
      endcase
    end

    // A cause set on the same edge as a clear survives the clear.
    cause_next     = (cause_reg & ~{NumRstSrc{bus.cause_clr_i}})
                   | (set_cause ? req_sync_reg : '0);
    lock_lost_next = (lock_lost_reg & ~bus.cause_clr_i) | (set_cause & ~lock_sync_reg);
  end

  assign bus.rst_domain_no = dom_reg;
  assign bus.strap_o       = strap_reg;
  assign bus.strap_valid_o = valid_reg;
  assign bus.rst_cause_o   = cause_reg;
  assign bus.lock_lost_o   = lock_lost_reg;

endmodule
